// File: rtl/mma_run_ctrl.sv
// Debug run controller for a small core: accepts host commands, gates the core
// clock enable for STEP/RUN/BREAK, and exposes host-visible I/O port registers.
module mma_run_ctrl #(
  parameter int WIDTH  = 16,
  parameter int NPORT  = 2,
  parameter int PSEL_W = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [PSEL_W-1:0]      cmd_port,
  input  logic [WIDTH-1:0]       cmd_arg,
  input  logic                   abort,
  input  logic                   core_halt,
  input  logic                   core_fault,
  input  logic                   core_break,
  output logic                   core_en,
  output logic                   core_reset,
  input  logic [NPORT*WIDTH-1:0] in_ports,
  output logic [NPORT*WIDTH-1:0] out_ports,
  output logic                   rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [1:0]             rsp_code,
  output logic                   busy
);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_RESET  = 3'd1;
  localparam logic [2:0] OP_STEP   = 3'd2;
  localparam logic [2:0] OP_RUN    = 3'd3;
  localparam logic [2:0] OP_BREAK  = 3'd4;
  localparam logic [2:0] OP_READ   = 3'd5;
  localparam logic [2:0] OP_WRITE  = 3'd6;
  localparam logic [2:0] OP_STATUS = 3'd7;

  localparam logic [1:0] CODE_DONE  = 2'd0;
  localparam logic [1:0] CODE_HALT  = 2'd1;
  localparam logic [1:0] CODE_FAULT = 2'd2;
  localparam logic [1:0] CODE_BREAK = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RST,
    S_EXEC,
    S_RESP
  } state_t;

  state_t           state_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] limit_reg;
  logic [WIDTH-1:0] cnt_reg;
  logic             first_reg;
  logic             rst_cnt_reg;
  logic             rsp_valid_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic [1:0]       rsp_code_reg;

  logic             accept;
  logic             wr_en;
  logic [NPORT-1:0] port_hit;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] status_data;
  logic             stop_break;
  logic             stop_count;
  logic             exec_stop;
  logic [1:0]       exec_code;

  assign accept      = cmd_valid && (state_reg == S_IDLE);
  assign wr_en       = accept && (cmd_op == OP_WRITE);
  assign status_data = WIDTH'({core_break, core_fault, core_halt});

  // One-hot port decode; an out-of-range index matches nothing, so reads
  // return zero and writes fall on the floor.
  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
      logic [WIDTH-1:0] port_q;

      assign port_hit[gi] = (cmd_port == PSEL_W'(gi));
      assign out_ports[gi*WIDTH +: WIDTH] = port_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          port_q <= '0;
        end else if (wr_en && port_hit[gi]) begin
          port_q <= cmd_arg;
        end
      end
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (port_hit[i]) begin
        rd_data = rd_data | in_ports[i*WIDTH +: WIDTH];
      end
    end
  end

  // Stop test runs on this cycle's flags so the core never gets the enable
  // for a cycle in which it is already halted, faulted or aborted.
  assign stop_break = (op_reg == OP_BREAK) && !first_reg && core_break;
  assign stop_count = (op_reg == OP_STEP) && (cnt_reg >= limit_reg);
  assign exec_stop  = core_fault || core_halt || stop_break || stop_count || abort;

  always_comb begin
    if (core_fault) begin
      exec_code = CODE_FAULT;
    end else if (core_halt) begin
      exec_code = CODE_HALT;
    end else if (stop_break) begin
      exec_code = CODE_BREAK;
    end else begin
      exec_code = CODE_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      op_reg        <= OP_NOP;
      limit_reg     <= '0;
      cnt_reg       <= '0;
      first_reg     <= 1'b0;
      rst_cnt_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_code_reg  <= CODE_DONE;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_reg    <= cmd_op;
            cnt_reg   <= '0;
            first_reg <= 1'b1;
            limit_reg <= (cmd_arg == '0) ? WIDTH'(1) : cmd_arg;
            unique case (cmd_op)
              OP_NOP: begin
                state_reg <= S_IDLE;
              end
              OP_RESET: begin
                rst_cnt_reg <= 1'b0;
                state_reg   <= S_RST;
              end
              OP_STEP, OP_RUN, OP_BREAK: begin
                state_reg <= S_EXEC;
              end
              OP_READ: begin
                rsp_data_reg  <= rd_data;
                rsp_code_reg  <= CODE_DONE;
                rsp_valid_reg <= 1'b1;
                state_reg     <= S_RESP;
              end
              OP_WRITE: begin
                rsp_data_reg  <= cmd_arg;
                rsp_code_reg  <= CODE_DONE;
                rsp_valid_reg <= 1'b1;
                state_reg     <= S_RESP;
              end
              OP_STATUS: begin
                rsp_data_reg  <= status_data;
                rsp_code_reg  <= CODE_DONE;
                rsp_valid_reg <= 1'b1;
                state_reg     <= S_RESP;
              end
              default: begin
                state_reg <= S_IDLE;
              end
            endcase
          end
        end
        S_RST: begin
          if (rst_cnt_reg) begin
            rsp_data_reg  <= '0;
            rsp_code_reg  <= CODE_DONE;
            rsp_valid_reg <= 1'b1;
            state_reg     <= S_RESP;
          end else begin
            rst_cnt_reg <= 1'b1;
          end
        end
        S_EXEC: begin
          first_reg <= 1'b0;
          if (exec_stop) begin
            rsp_data_reg  <= cnt_reg;
            rsp_code_reg  <= exec_code;
            rsp_valid_reg <= 1'b1;
            state_reg     <= S_RESP;
          end else if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + WIDTH'(1);
          end
        end
        S_RESP: begin
          rsp_valid_reg <= 1'b0;
          state_reg     <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign core_reset = (state_reg == S_RST);
  assign core_en    = (state_reg == S_EXEC) && !exec_stop;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_code   = rsp_code_reg;

endmodule

// File: tb/tb_mma_run_ctrl.sv
// Self-checking bench for mma_run_ctrl: directed and randomized commands checked
// against a cycle-indexed reference model of the run-control rules.
module tb_mma_run_ctrl;
  localparam int W  = 16;
  localparam int NP = 2;
  localparam int PW = 1;

  localparam logic [2:0] NOP = 3'd0, RESETC = 3'd1, STEP = 3'd2, RUN = 3'd3,
                         BRK = 3'd4, READ = 3'd5, WRITE = 3'd6, STATUS = 3'd7;
  localparam int NEVER = 100000;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [PW-1:0] cmd_port;
  logic [W-1:0]  cmd_arg;
  logic          abort, core_halt, core_fault, core_break;
  logic          core_en, core_reset;
  logic [NP*W-1:0] in_ports, out_ports;
  logic          rsp_valid;
  logic [W-1:0]  rsp_data;
  logic [1:0]    rsp_code;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] shadow [NP];

  mma_run_ctrl #(.WIDTH(W), .NPORT(NP), .PSEL_W(PW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_port(cmd_port), .cmd_arg(cmd_arg), .abort(abort),
    .core_halt(core_halt), .core_fault(core_fault), .core_break(core_break),
    .core_en(core_en), .core_reset(core_reset), .in_ports(in_ports),
    .out_ports(out_ports), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_code(rsp_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NP*W-1:0] shadow_vec();
    logic [NP*W-1:0] v = '0;
    for (int i = 0; i < NP; i++) v[i*W +: W] = shadow[i];
    return v;
  endfunction

  // Reference: walk EXEC cycles e = 0,1,.. applying the stop rules in priority order.
  function automatic void model_exec(input logic [2:0] op, input int arg, input int f, input int h,
                                     input int b, input int a, output int pulses, output int code);
    int lim = (arg == 0) ? 1 : arg;
    pulses = -1;
    code = 0;
    for (int e = 0; e < 1000; e++) begin
      if (e >= f) code = 2;
      else if (e >= h) code = 1;
      else if (op == BRK && e > 0 && e >= b) code = 3;
      else if (e >= a || (op == STEP && e >= lim)) code = 0;
      else continue;
      pulses = e;
      return;
    end
  endfunction

  task automatic send(input logic [2:0] op, input logic [PW-1:0] port, input logic [W-1:0] arg);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_port = port;
    cmd_arg = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic exec_check(input string name, input logic [2:0] op, input int arg,
                            input int f, input int h, input int b, input int a);
    int exp_p, exp_c, pulses, lat;
    bit overlap;
    model_exec(op, arg, f, h, b, a, exp_p, exp_c);
    send(op, '0, W'(arg));
    pulses = 0;
    lat = -1;
    overlap = 0;
    for (int e = 0; e < 600; e++) begin
      core_fault = (e >= f);
      core_halt  = (e >= h);
      core_break = (e >= b);
      abort      = (e >= a);
      @(negedge clk);
      if (core_en && core_reset) overlap = 1;
      if (rsp_valid) begin
        lat = e;
        break;
      end
      if (core_en) pulses++;
      tick();
    end
    core_fault = 0; core_halt = 0; core_break = 0; abort = 0;
    checks += 4;
    if (lat !== exp_p + 1 || overlap) begin
      errors++;
      $display("FAIL %s_latency: rsp at exec cycle %0d overlap=%0b, required %0d", name, lat, overlap, exp_p + 1);
    end
    if (pulses !== exp_p) begin
      errors++;
      $display("FAIL %s_pulses: got %0d required %0d", name, pulses, exp_p);
    end
    if (rsp_code !== 2'(exp_c)) begin
      errors++;
      $display("FAIL %s_code: got %0d required %0d", name, rsp_code, exp_c);
    end
    if (rsp_data !== W'(exp_p)) begin
      errors++;
      $display("FAIL %s_data: got %0d required %0d", name, rsp_data, exp_p);
    end
    $display("exec %s op=%0d arg=%0d pulses=%0d code=%0d", name, op, arg, pulses, rsp_code);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 0; cmd_op = NOP; cmd_port = '0; cmd_arg = '0;
    abort = 0; core_halt = 0; core_fault = 0; core_break = 0; in_ports = '0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < NP; i++) shadow[i] = '0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, core_en, core_reset, rsp_valid} !== 5'b10000 || rsp_data !== '0 ||
        rsp_code !== 2'd0 || out_ports !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b busy=%b en=%b crst=%b rv=%b data=%h code=%0d out=%h required 1,0,0,0,0,0,0,0",
               cmd_ready, busy, core_en, core_reset, rsp_valid, rsp_data, rsp_code, out_ports);
    end
    $display("reset done");
    tick();
  endtask

  task automatic test_reset_cmd();
    send(RESETC, '0, 16'h7777);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (core_reset !== (c <= 2) || rsp_valid !== (c == 3) || core_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_cmd_c%0d: crst=%b rv=%b en=%b required %b,%b,0", c, core_reset, rsp_valid,
                 core_en, c <= 2, c == 3);
      end
      if (c == 3) begin
        checks++;
        if (rsp_code !== 2'd0 || rsp_data !== '0) begin
          errors++;
          $display("FAIL reset_cmd_rsp: code=%0d data=%h required 0,0", rsp_code, rsp_data);
        end
      end
      tick();
    end
    $display("reset_cmd rsp code=%0d data=%h", rsp_code, rsp_data);
  endtask

  task automatic test_write_read();
    logic [W-1:0] v, exp;
    logic [PW-1:0] p;
    bit is_wr;
    send(WRITE, 1'b1, 16'hA5A5);
    shadow[1] = 16'hA5A5;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hA5A5 || rsp_code !== 2'd0 || out_ports !== shadow_vec()) begin
      errors++;
      $display("FAIL write_a5a5: rv=%b data=%h code=%0d out=%h required 1,a5a5,0,%h", rsp_valid, rsp_data,
               rsp_code, out_ports, shadow_vec());
    end
    $display("write port 1 data a5a5 out=%h", out_ports);
    tick();
    in_ports = {16'hBEEF, 16'h1234};
    send(READ, 1'b0, '0);
    in_ports = {16'h0F0F, 16'h9999};
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234 || rsp_code !== 2'd0) begin
      errors++;
      $display("FAIL read_1234: rv=%b data=%h code=%0d required 1,1234,0", rsp_valid, rsp_data, rsp_code);
    end
    $display("read port 0 data=%h", rsp_data);
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'h1234) begin
      errors++;
      $display("FAIL rsp_hold: rv=%b data=%h required 0,1234", rsp_valid, rsp_data);
    end
    tick();
    for (int k = 0; k < 10; k++) begin
      is_wr = $urandom_range(0, 1);
      p = PW'($urandom_range(0, NP - 1));
      v = W'($urandom);
      in_ports = {W'($urandom), W'($urandom)};
      exp = is_wr ? v : in_ports[p*W +: W];
      send(is_wr ? WRITE : READ, p, v);
      if (is_wr) shadow[p] = v;
      in_ports = ~in_ports;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || out_ports !== shadow_vec()) begin
        errors++;
        $display("FAIL rw_rand%0d: rv=%b data=%h out=%h required 1,%h,%h", k, rsp_valid, rsp_data,
                 out_ports, exp, shadow_vec());
      end
      $display("%s port %0d data=%h out=%h", is_wr ? "write" : "read", p, rsp_data, out_ports);
      tick();
    end
  endtask

  task automatic test_status_nop();
    logic [2:0] fl;
    for (int k = 0; k < 6; k++) begin
      fl = 3'($urandom);
      {core_break, core_fault, core_halt} = fl;
      send(STATUS, '0, '0);
      {core_break, core_fault, core_halt} = ~fl;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== W'(fl) || rsp_code !== 2'd0) begin
        errors++;
        $display("FAIL status%0d: rv=%b data=%h code=%0d required 1,%h,0", k, rsp_valid, rsp_data, rsp_code, fl);
      end
      $display("status flags=%b data=%h", fl, rsp_data);
      {core_break, core_fault, core_halt} = 3'b000;
      tick();
    end
    send(NOP, '0, '0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nop: rv=%b rdy=%b busy=%b required 0,1,0", rsp_valid, cmd_ready, busy);
    end
    $display("nop accepted, no response");
    tick();
  endtask

  task automatic test_exec_directed();
    exec_check("step5", STEP, 5, NEVER, NEVER, NEVER, NEVER);
    exec_check("step0", STEP, 0, NEVER, NEVER, NEVER, NEVER);
    exec_check("run_halt3", RUN, 0, NEVER, 3, NEVER, NEVER);
    exec_check("run_fault_halt3", RUN, 0, 3, 3, NEVER, NEVER);
    exec_check("run_halt0", RUN, 0, NEVER, 0, NEVER, NEVER);
    exec_check("break_early", BRK, 0, NEVER, NEVER, 0, NEVER);
    exec_check("break_halt0", BRK, 0, NEVER, 0, 0, NEVER);
    exec_check("run_abort4", RUN, 0, NEVER, NEVER, NEVER, 4);
    exec_check("step_abort0", STEP, 3, NEVER, NEVER, NEVER, 0);
  endtask

  task automatic test_exec_random();
    logic [2:0] op;
    int f, h, b, a;
    for (int k = 0; k < 30; k++) begin
      op = 3'($urandom_range(2, 4));
      f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : NEVER;
      h = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : NEVER;
      b = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 30)) : NEVER;
      a = int'($urandom_range(0, 40));
      exec_check($sformatf("rand%0d", k), op, int'($urandom_range(0, 20)), f, h, b, a);
    end
  endtask

  task automatic test_busy_ignore();
    int pulses = 0;
    send(RUN, '0, '0);
    for (int e = 0; e < 20; e++) begin
      cmd_valid = (e == 1 || e == 2);
      cmd_op = WRITE; cmd_port = '0; cmd_arg = 16'hDEAD;
      abort = (e >= 4);
      @(negedge clk);
      if (e == 1) begin
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_ready: rdy=%b busy=%b required 0,1", cmd_ready, busy);
        end
      end
      if (rsp_valid) break;
      if (core_en) pulses++;
      tick();
    end
    cmd_valid = 0; abort = 0;
    checks++;
    if (pulses !== 4 || rsp_data !== 16'd4 || out_ports !== shadow_vec()) begin
      errors++;
      $display("FAIL busy_ignore: pulses=%0d data=%0d out=%h required 4,4,%h", pulses, rsp_data,
               out_ports, shadow_vec());
    end
    $display("busy ignore pulses=%0d out=%h", pulses, out_ports);
    tick();
  endtask

  task automatic test_reset_mid_run();
    send(WRITE, 1'b0, 16'h5A5A);
    shadow[0] = 16'h5A5A;
    tick();
    send(RUN, '0, '0);
    tick(); tick(); tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (core_en !== 1'b1 || out_ports === '0) begin
      errors++;
      $display("FAIL mid_run_pre: en=%b out=%h required 1,nonzero", core_en, out_ports);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < NP; i++) shadow[i] = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (core_en !== 1'b0 || core_reset !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
          out_ports !== shadow_vec()) begin
        errors++;
        $display("FAIL mid_run_reset_c%0d: en=%b crst=%b rv=%b busy=%b out=%h required 0,0,0,0,0", c,
                 core_en, core_reset, rsp_valid, busy, out_ports);
      end
      tick();
    end
    $display("reset mid-run: en=%b rv=%b out=%h", core_en, rsp_valid, out_ports);
  endtask

  initial begin
    test_reset();
    test_reset_cmd();
    test_write_read();
    test_reset_cmd();
    test_status_nop();
    test_exec_directed();
    test_exec_random();
    test_busy_ignore();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mma_run_ctrl.md
MMA_RUN_CTRL -- requirements
Module: mma_run_ctrl

Interface
REQ-001 Parameter WIDTH, 16, data width of ports, cmd_arg and rsp_data.
REQ-002 Parameter NPORT, 2, number of input ports and number of output ports (each NPORT).
REQ-003 Parameter PSEL_W, 1, width of cmd_port; NPORT <= 2**PSEL_W.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  command offered; cmd_ready  output  1  command accepted when both high.
REQ-007 cmd_op  input  3  0 NOP, 1 RESET, 2 STEP, 3 RUN, 4 BREAK, 5 READ, 6 WRITE, 7 STATUS.
REQ-008 cmd_port  input  PSEL_W  port index for READ/WRITE; cmd_arg  input  WIDTH  STEP count or WRITE data.
REQ-009 abort  input  1  stop an executing STEP/RUN/BREAK.
REQ-010 core_halt, core_fault, core_break  input  1 each  core status flags.
REQ-011 core_en  output  1  core clock enable, one core cycle per high cycle; core_reset  output  1  core reset.
REQ-012 in_ports  input  NPORT*WIDTH  port i at [i*WIDTH +: WIDTH]; out_ports  output  NPORT*WIDTH  same packing, registered.
REQ-013 rsp_valid  output  1  one-cycle response pulse, no backpressure; rsp_data  output  WIDTH; rsp_code  output  2  0 DONE, 1 HALT, 2 FAULT, 3 BREAK.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, RST, EXEC, RESP; cmd_ready SHALL equal (state == IDLE).
REQ-016 Accept in IDLE at cycle N: NOP -> no response, stay IDLE; READ/WRITE/STATUS -> RESP, rsp_valid at N+1; RESET -> RST; STEP/RUN/BREAK -> EXEC.
REQ-017 RST SHALL hold core_reset high exactly 2 cycles (N+1, N+2), core_en low, then RESP with rsp_valid at N+3, code DONE, data 0.
REQ-018 READ SHALL return in_ports[cmd_port] sampled at N; index >= NPORT returns 0; code DONE.
REQ-019 WRITE SHALL update out_ports[cmd_port] at the accept edge; index >= NPORT ignored; rsp_data echoes cmd_arg; code DONE.
REQ-020 STATUS SHALL return rsp_data = {zeros, core_break, core_fault, core_halt} sampled at N; code DONE.
REQ-021 EXEC each cycle: evaluate stop condition on current flag inputs; if stop -> core_en low, go RESP; else core_en high, cycle counter +1.
REQ-022 Stop priority SHALL be FAULT > HALT > BREAK > abort/count exhaustion (code DONE).
REQ-023 RUN stops on fault or halt only; if either is high in first EXEC cycle, zero core cycles run.
REQ-024 BREAK stops on fault, halt or break, except break flag is ignored in first EXEC cycle (at least one core cycle unless halt/fault).
REQ-025 STEP runs exactly max(cmd_arg,1) core cycles unless stopped earlier; cmd_arg = 0 treated as 1.
REQ-026 abort high in an EXEC cycle SHALL stop before that cycle's core_en (code DONE unless a flag stop applies).
REQ-027 Cycle counter WIDTH bits, cleared on accept, saturating at all-ones; rsp_data for STEP/RUN/BREAK = cycles executed.
REQ-028 RESP lasts one cycle with rsp_valid high, then IDLE; rsp_data/rsp_code hold until next response.
REQ-029 core_en and core_reset SHALL never be high simultaneously; core_en low outside EXEC.
REQ-030 cmd_valid while busy SHALL be ignored (not accepted, no side effect).

Reset
REQ-031 reset high: state IDLE, cmd_ready 1 after reset deasserts, core_en 0, core_reset 0, rsp_valid 0, rsp_data 0, rsp_code 0, busy 0, out_ports 0, counter 0.
REQ-032 reset mid-command SHALL abandon it with no response and cut core_en/core_reset the same edge.

Verification
REQ-033 Reset, RESET cmd at cycle 0 -> core_reset high cycles 1-2, rsp_valid cycle 3, code 0, data 0.
REQ-034 WRITE port 1 data 0xA5A5, then READ port 0 with in_ports[0] = 0x1234 -> out_ports[1] = 0xA5A5, rsp_data 0x1234.
REQ-035 STEP cmd_arg 5, flags low -> 5 core_en pulses, rsp_data 5, code DONE; STEP cmd_arg 0 -> 1 pulse.
REQ-036 RUN, core_halt raised after 3rd core_en -> exactly 3 pulses, code HALT; raise fault and halt together -> code FAULT.
REQ-037 BREAK with core_break already high -> 1 pulse then stop, code BREAK, rsp_data 1.
REQ-038 RUN then abort after 4 pulses -> code DONE, data 4; repeat with reset mid-RUN -> no rsp_valid, core_en low next cycle, out_ports 0.
